shift_tx_sequencer: RTL and testbench



---
 rtl/shift_tx_sequencer_if.sv | 29 ++
 rtl/shift_tx_sequencer.sv | 105 ++++++++++
 tb/tb_shift_tx_sequencer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/shift_tx_sequencer_if.sv
// Bundle between the serial-transmit sequencer, its word source and the external right shift register.
// The slave modport is the sequencer; the master modport is the surrounding logic.
interface shift_tx_sequencer_if #(
    parameter int WIDTH = 5
);
    logic [WIDTH-1:0] dataIn;
    logic             dataValid;
    logic             dataReady;
    logic [WIDTH-1:0] registerOut;
    logic             registerLoad;
    logic [WIDTH-1:0] registerPreset;
    logic             registerShift;
    logic             registerSerialInput;
    logic             serialOut;
    logic             busy;
    logic             done;

    modport master (
        output dataIn, dataValid, registerOut,
        input  dataReady, registerLoad, registerPreset, registerShift,
        input  registerSerialInput, serialOut, busy, done
    );

    modport slave (
        input  dataIn, dataValid, registerOut,
        output dataReady, registerLoad, registerPreset, registerShift,
        output registerSerialInput, serialOut, busy, done
    );
endinterface

// File: rtl/shift_tx_sequencer.sv
// Drives an external right shift register as a UART-style transmitter:
// one word per frame, framed with a low start bit and a high stop bit.
module shift_tx_sequencer #(
    parameter int   WIDTH         = 5,
    parameter int   TICKS_PER_BIT = 4,
    parameter logic FILL_BIT      = 1'b0
) (
    input logic                  clockpulse,
    input logic                  clear,
    shift_tx_sequencer_if.slave  bus
);
    localparam int TICK_W = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(WIDTH + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

    state_t              state;
    logic [TICK_W-1:0]   tick;
    logic [BIT_W-1:0]    bit_cnt;
    logic [WIDTH-1:0]    preset;
    logic                done_r;
    logic                tick_last;
    logic                serial;
    logic                unused_reg_bits;

    assign tick_last = (tick == TICK_LAST);

    always_ff @(posedge clockpulse or posedge clear) begin
        if (clear) begin
            state   <= IDLE;
            preset  <= '0;
            tick    <= '0;
            bit_cnt <= '0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.dataValid) begin
                        preset <= bus.dataIn;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    tick  <= '0;
                    state <= START;
                end
                START: begin
                    if (tick_last) begin
                        tick    <= '0;
                        bit_cnt <= '0;
                        state   <= DATA;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                // The shift strobe fires on the last tick of each bit, so the
                // next bit appears on registerOut[0] at the start of its period.
                DATA: begin
                    if (tick_last) begin
                        tick    <= '0;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST) begin
                            state <= STOP;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_last) begin
                        tick   <= '0;
                        done_r <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Decoded from registered state so clear forces the line high at once.
    always_comb begin
        serial = 1'b1;
        case (state)
            START:   serial = 1'b0;
            DATA:    serial = bus.registerOut[0];
            default: serial = 1'b1;
        endcase
    end

    assign unused_reg_bits         = ^bus.registerOut;
    assign bus.serialOut           = serial;
    assign bus.dataReady           = (state == IDLE);
    assign bus.busy                = (state != IDLE);
    assign bus.registerLoad        = (state == LOAD);
    assign bus.registerShift       = (state == DATA) && tick_last;
    assign bus.registerPreset      = preset;
    assign bus.registerSerialInput = FILL_BIT;
    assign bus.done                = done_r;
endmodule

// File: tb/tb_shift_tx_sequencer.sv
// Scoreboard bench: two sequencers (4 and 1 ticks per bit), each driving a modelled shift register.
module tb_shift_tx_sequencer;
    localparam int W = 5;

    logic clk = 1'b0;
    logic clear;
    int   nvec = 0;
    int   nerr = 0;

    shift_tx_sequencer_if #(.WIDTH(W)) ifa ();
    shift_tx_sequencer_if #(.WIDTH(W)) ifb ();

    shift_tx_sequencer #(.WIDTH(W), .TICKS_PER_BIT(4), .FILL_BIT(1'b0)) dut_a (
        .clockpulse (clk),
        .clear      (clear),
        .bus        (ifa)
    );

    shift_tx_sequencer #(.WIDTH(W), .TICKS_PER_BIT(1), .FILL_BIT(1'b0)) dut_b (
        .clockpulse (clk),
        .clear      (clear),
        .bus        (ifb)
    );

    always #5 clk = ~clk;

    // External right shift registers
    logic [W-1:0] reg_a, reg_b;
    always @(posedge clk or posedge clear) begin
        if (clear) reg_a <= '0;
        else if (ifa.registerLoad) reg_a <= ifa.registerPreset;
        else if (ifa.registerShift) reg_a <= {ifa.registerSerialInput, reg_a[W-1:1]};
    end
    always @(posedge clk or posedge clear) begin
        if (clear) reg_b <= '0;
        else if (ifb.registerLoad) reg_b <= ifb.registerPreset;
        else if (ifb.registerShift) reg_b <= {ifb.registerSerialInput, reg_b[W-1:1]};
    end
    assign ifa.registerOut = reg_a;
    assign ifb.registerOut = reg_b;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Entry layout: {serialOut, load, shift, busy, ready, done, preset[4:0]}
    function automatic logic [10:0] frame_entry(input logic [W-1:0] w, input int t, input int k);
        logic s, l, sh, b, r, d;
        int   j;
        s = 1'b1; l = 1'b0; sh = 1'b0; b = 1'b1; r = 1'b0; d = 1'b0;
        if (k == 0) begin
            l = 1'b1;
        end else if (k <= t) begin
            s = 1'b0;
        end else if (k <= (W + 1) * t) begin
            j  = k - t - 1;
            s  = w[j / t];
            sh = ((j % t) == (t - 1));
        end else if (k <= (W + 2) * t) begin
            s = 1'b1;
        end else begin
            b = 1'b0; r = 1'b1; d = 1'b1;
        end
        return {s, l, sh, b, r, d, w};
    endfunction

    logic [10:0]  q_a[$];
    logic [10:0]  q_b[$];
    logic [W-1:0] last_a = '0;
    logic [W-1:0] last_b = '0;
    logic [10:0]  got_a, exp_a, got_b, exp_b;

    always @(negedge clk) begin
        got_a = {ifa.serialOut, ifa.registerLoad, ifa.registerShift, ifa.busy,
                 ifa.dataReady, ifa.done, ifa.registerPreset};
        if (clear) begin
            q_a.delete();
            last_a = '0;
            chk("A_rst", 32'(got_a), 32'({6'b100010, 5'd0}));
        end else begin
            if (q_a.size() > 0) exp_a = q_a.pop_front();
            else exp_a = {6'b100010, last_a};
            chk("A_cyc", 32'(got_a), 32'(exp_a));
            if (q_a.size() == 0 && ifa.dataValid) begin
                last_a = ifa.dataIn;
                for (int k = 0; k < (W + 2) * 4 + 2; k++) q_a.push_back(frame_entry(ifa.dataIn, 4, k));
            end
        end
    end

    always @(negedge clk) begin
        got_b = {ifb.serialOut, ifb.registerLoad, ifb.registerShift, ifb.busy,
                 ifb.dataReady, ifb.done, ifb.registerPreset};
        if (clear) begin
            q_b.delete();
            last_b = '0;
            chk("B_rst", 32'(got_b), 32'({6'b100010, 5'd0}));
        end else begin
            if (q_b.size() > 0) exp_b = q_b.pop_front();
            else exp_b = {6'b100010, last_b};
            chk("B_cyc", 32'(got_b), 32'(exp_b));
            if (q_b.size() == 0 && ifb.dataValid) begin
                last_b = ifb.dataIn;
                for (int k = 0; k < (W + 2) * 1 + 2; k++) q_b.push_back(frame_entry(ifb.dataIn, 1, k));
            end
        end
    end

    task automatic wait_ready_a();
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (ifa.dataReady) seen = 1'b1;
        end
        if (!seen) chk("A_hs_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_a(input logic [W-1:0] w);
        ifa.dataIn    = w;
        ifa.dataValid = 1'b1;
        wait_ready_a();
        @(posedge clk); #1;
        ifa.dataValid = 1'b0;
    endtask

    task automatic send_b(input logic [W-1:0] w);
        bit seen = 1'b0;
        ifb.dataIn    = w;
        ifb.dataValid = 1'b1;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (ifb.dataReady) seen = 1'b1;
        end
        if (!seen) chk("B_hs_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        ifb.dataValid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        clear         = 1'b1;
        ifa.dataIn    = '0;
        ifa.dataValid = 1'b0;
        ifb.dataIn    = '0;
        ifb.dataValid = 1'b0;
        cycles(2);
        // clear wins over a simultaneous valid word
        ifa.dataIn    = 5'b11011;
        ifa.dataValid = 1'b1;
        cycles(2);
        ifa.dataValid = 1'b0;
        clear         = 1'b0;
        cycles(10);

        send_a(5'b10110);
        cycles(30);
        chk("A_fill_1", 32'(reg_a), 32'd0);

        // back-to-back frames with dataValid held high
        ifa.dataIn    = 5'b11111;
        ifa.dataValid = 1'b1;
        wait_ready_a();
        @(posedge clk); #1;
        ifa.dataIn = 5'b00001;
        wait_ready_a();
        @(posedge clk); #1;
        ifa.dataValid = 1'b0;
        cycles(30);
        chk("A_fill_2", 32'(reg_a), 32'd0);

        // word offered mid-frame must be ignored
        send_a(5'b11001);
        cycles(12);
        ifa.dataIn    = 5'b01010;
        ifa.dataValid = 1'b1;
        cycles(1);
        ifa.dataValid = 1'b0;
        cycles(17);
        chk("A_fill_3", 32'(reg_a), 32'd0);

        // clear during the third data bit
        send_a(5'b01011);
        repeat (13) @(posedge clk);
        #2;
        clear = 1'b1;
        #1;
        chk("midclr_ser", 32'(ifa.serialOut), 32'd1);
        chk("midclr_busy", 32'(ifa.busy), 32'd0);
        chk("midclr_done", 32'(ifa.done), 32'd0);
        @(posedge clk); #1;
        clear = 1'b0;
        cycles(3);

        send_a(5'b00111);
        cycles(30);
        chk("A_fill_4", 32'(reg_a), 32'd0);

        send_b(5'b10000);
        cycles(10);
        chk("B_fill", 32'(reg_b), 32'd0);
        chk("A_q_empty", 32'(q_a.size()), 32'd0);
        chk("B_q_empty", 32'(q_b.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
